mcac_chan_sched: RTL and testbench

Per-frame channel scheduler for the multi-channel ADPCM codec datapath: on each 8 kHz frame strobe it walks the enabled channels in ascending index order, issuing one start/done transaction per channel to the shared per-sample pipeline (adaptive quantizer and neighbouring stages). It supervises each transaction with a watchdog, reports frame completion, and flags overruns and stalled transactions. It sits between the frame-timing logic and the ADAP_QUAN-class datapath blocks.

---
 rtl/mcac_pkg.sv | 31 +++
 rtl/mcac_chan_sched_if.sv | 30 +++
 rtl/mcac_wdog.sv | 34 +++
 rtl/mcac_chan_sched.sv | 143 ++++++++++++++
 tb/tb_mcac_chan_sched.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcac_pkg.sv
// Shared types and sizing helpers for the multi-channel ADPCM channel scheduler.
package mcac_pkg;

    // Scheduler control states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEEK  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FDONE = 3'd4
    } sched_state_t;

    localparam int DEF_NCH     = 32;
    localparam int DEF_CH_W    = 5;
    localparam int DEF_TIMEOUT = 63;

    // The channel pointer needs one extra bit so it can hold NCH itself,
    // which marks the end of the scan.
    function automatic int ptr_width(input int ch_w);
        return ch_w + 1;
    endfunction

    // Smallest width able to hold max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

endpackage

// File: rtl/mcac_chan_sched_if.sv
// Frame-timing / datapath handshake bundle of the channel scheduler.
// slave  : the scheduler itself.
// master : the surrounding frame-timing logic and datapath.
interface mcac_chan_sched_if
    import mcac_pkg::*;
#(
    parameter int NCH  = DEF_NCH,
    parameter int CH_W = DEF_CH_W
);
    logic            frame_sync;
    logic [NCH-1:0]  ch_en;
    logic            dp_done;
    logic            err_clr;
    logic            dp_start;
    logic [CH_W-1:0] dp_ch;
    logic            busy;
    logic            frame_done;
    logic            overrun;
    logic            timeout_err;

    modport slave (
        input  frame_sync, ch_en, dp_done, err_clr,
        output dp_start, dp_ch, busy, frame_done, overrun, timeout_err
    );

    modport master (
        output frame_sync, ch_en, dp_done, err_clr,
        input  dp_start, dp_ch, busy, frame_done, overrun, timeout_err
    );
endinterface

// File: rtl/mcac_wdog.sv
// Transaction watchdog: counts WAIT cycles and raises a registered expiry
// flag that is high exactly while the count equals TIMEOUT.
module mcac_wdog
    import mcac_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
)
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TMR_W = cnt_width(TIMEOUT);

    logic [TMR_W-1:0] tmr;

    // Counter and expiry flag; expiry is computed one step ahead so it
    // lines up with the cycle in which tmr holds TIMEOUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr     <= '0;
            expired <= 1'b0;
        end else if (clr) begin
            tmr     <= '0;
            expired <= (TIMEOUT == 0);
        end else if (en && !expired) begin
            tmr     <= tmr + 1'b1;
            expired <= (tmr == TMR_W'(TIMEOUT - 1));
        end
    end

endmodule

// File: rtl/mcac_chan_sched.sv
// Per-frame channel scheduler: on each accepted frame strobe it walks the
// enabled channels in ascending order, issues one start/done transaction
// per channel to the shared datapath, supervises each with a watchdog and
// reports frame completion, overruns and abandoned transactions.
module mcac_chan_sched
    import mcac_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int CH_W    = DEF_CH_W,
    parameter int TIMEOUT = DEF_TIMEOUT
)
(
    input  logic clk,
    input  logic reset,
    input  logic scan_en,
    input  logic scan_in0,
    output logic scan_out0,
    mcac_chan_sched_if.slave bus
);
    localparam int PTR_W = ptr_width(CH_W);

    sched_state_t    state;
    logic [PTR_W-1:0] ptr;
    logic [NCH-1:0]  en_q;
    logic [CH_W-1:0] ptr_lo;
    logic            ptr_end;

    logic            dp_start_q;
    logic [CH_W-1:0] dp_ch_q;
    logic            busy_q;
    logic            frame_done_q;
    logic            overrun_q;
    logic            timeout_err_q;

    logic            wd_clr;
    logic            wd_en;
    logic            wd_expired;
    logic            to_hit;

    // Scan pins are placeholders until scan insertion.
    logic            scan_unused;
    assign scan_unused = scan_en ^ scan_in0;
    assign scan_out0   = 1'b0;

    assign ptr_lo  = ptr[CH_W-1:0];
    assign ptr_end = (ptr == PTR_W'(NCH));

    // Watchdog restarts on every issue and counts only while waiting
    // without a completion.
    assign wd_clr = (state == ST_ISSUE);
    assign wd_en  = (state == ST_WAIT) && !bus.dp_done;
    // A completion in the expiry cycle wins over the timeout.
    assign to_hit = (state == ST_WAIT) && !bus.dp_done && wd_expired;

    mcac_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    // Scheduler FSM with registered outputs and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            en_q          <= '0;
            dp_start_q    <= 1'b0;
            dp_ch_q       <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            dp_start_q   <= 1'b0;
            frame_done_q <= 1'b0;

            // Sticky flags: a new set beats a simultaneous clear.
            if (bus.frame_sync && (state != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end else if (bus.err_clr) begin
                overrun_q <= 1'b0;
            end

            if (to_hit) begin
                timeout_err_q <= 1'b1;
            end else if (bus.err_clr) begin
                timeout_err_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.frame_sync) begin
                        en_q   <= bus.ch_en;
                        ptr    <= '0;
                        state  <= ST_SEEK;
                        busy_q <= 1'b1;
                    end
                end
                ST_SEEK: begin
                    if (ptr_end) begin
                        state        <= ST_FDONE;
                        frame_done_q <= 1'b1;
                    end else if (en_q[ptr_lo]) begin
                        state      <= ST_ISSUE;
                        dp_start_q <= 1'b1;
                        dp_ch_q    <= ptr_lo;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.dp_done || wd_expired) begin
                        ptr   <= ptr + 1'b1;
                        state <= ST_SEEK;
                    end
                end
                ST_FDONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dp_start    = dp_start_q;
    assign bus.dp_ch       = dp_ch_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mcac_chan_sched.sv
// Bench for mcac_chan_sched: a frame-level timeline model computes, from
// channel masks and chosen datapath latencies, the cycle of every issue,
// transaction end and frame end; a single compare process checks every
// output on every cycle against that timeline.
module tb_mcac_chan_sched;
    import mcac_pkg::*;

    localparam int NCH  = 32;
    localparam int CH_W = 5;
    localparam int TO   = 63;
    localparam int MAXC = 8192;
    localparam int NEVER = 100000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic scan_en = 1'b0;
    logic scan_in0 = 1'b0;
    logic scan_out0;

    always #5 clk = ~clk;

    mcac_chan_sched_if #(.NCH(NCH), .CH_W(CH_W)) bus();

    mcac_chan_sched #(.NCH(NCH), .CH_W(CH_W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_en   (scan_en),
        .scan_in0  (scan_in0),
        .scan_out0 (scan_out0),
        .bus       (bus)
    );

    int errors = 0;
    int checks = 0;

    // Stimulus timeline (value driven during segment cycle c).
    bit             s_sync [0:MAXC];
    bit             s_done [0:MAXC];
    bit             s_clr  [0:MAXC];
    logic [NCH-1:0] s_en   [0:MAXC];
    // Model timeline (expected output during segment cycle c).
    bit             e_start [0:MAXC];
    int             iss_ch  [0:MAXC];
    bit             e_busy  [0:MAXC];
    bit             e_fd    [0:MAXC];
    bit             e_ovr   [0:MAXC];
    bit             e_to    [0:MAXC];
    int             e_ch    [0:MAXC];
    bit             in_wait [0:MAXC];
    bit             to_evt  [0:MAXC];
    // Observed DUT outputs per cycle.
    logic           d_start [0:MAXC];
    logic           d_fd    [0:MAXC];
    logic           d_ovr   [0:MAXC];
    logic           d_to    [0:MAXC];

    int cur_ch;
    bit cur_ovr;
    bit cur_to;
    int cyc = 0;
    bit running = 1'b0;

    task automatic check(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, got, exp);
        end
    endtask

    task automatic plan_clear();
        for (int c = 0; c <= MAXC; c++) begin
            s_sync[c] = 0; s_done[c] = 0; s_clr[c] = 0; s_en[c] = $urandom;
            e_start[c] = 0; iss_ch[c] = 0; e_busy[c] = 0; e_fd[c] = 0;
            e_ovr[c] = 0; e_to[c] = 0; e_ch[c] = 0; in_wait[c] = 0; to_evt[c] = 0;
            d_start[c] = 0; d_fd[c] = 0; d_ovr[c] = 0; d_to[c] = 0;
        end
    endtask

    // One accepted frame starting with the strobe in cycle k.
    // mode 0: every channel answers after 3 WAIT cycles
    // mode 1: random latency, occasionally exactly at the limit or never
    // mode 2: every channel answers in the very cycle the watchdog expires
    task automatic plan_frame(input int k, input logic [NCH-1:0] mask, input int mode,
                              input int dead_ch, output int fd);
        int s, lat, d, iss, r;
        s_sync[k] = 1;
        s_en[k]   = mask;
        s = k + 1;                       // SEEK of channel 0
        for (int p = 0; p < NCH; p++) begin
            if (mask[p]) begin
                iss = s + 1;
                e_start[iss] = 1;
                iss_ch[iss]  = p;
                if (p == dead_ch) lat = NEVER;
                else if (mode == 0) lat = 3;
                else if (mode == 2) lat = TO + 1;
                else begin
                    r = $urandom_range(0, 15);
                    lat = (r == 0) ? TO + 1 : (r == 1) ? NEVER : $urandom_range(1, 6);
                end
                d = (lat > TO + 1) ? TO + 1 : lat;
                if (lat <= TO + 1) s_done[iss + lat] = 1;
                else to_evt[iss + TO + 1] = 1;
                for (int w = iss + 1; w <= iss + d; w++) in_wait[w] = 1;
                s = iss + d + 1;
            end else begin
                s = s + 1;
            end
        end
        fd = s + 1;                      // FDONE follows SEEK at ptr==NCH
        e_fd[fd] = 1;
        for (int c = k + 1; c <= fd; c++) e_busy[c] = 1;
    endtask

    task automatic add_noise(input int len);
        for (int c = 0; c < len; c++) begin
            if (e_busy[c] && $urandom_range(0, 47) == 0) s_sync[c] = 1;
            if (!in_wait[c] && $urandom_range(0, 15) == 0) s_done[c] = 1;
            if ($urandom_range(0, 15) == 0) s_clr[c] = 1;
        end
    endtask

    task automatic build_exp(input int len);
        int ch; bit ovr, to;
        ch = cur_ch; ovr = cur_ovr; to = cur_to;
        for (int c = 0; c < len; c++) begin
            if (e_start[c]) ch = iss_ch[c];
            e_ch[c]  = ch;
            e_ovr[c] = ovr;
            e_to[c]  = to;
            if (s_sync[c] && e_busy[c]) ovr = 1; else if (s_clr[c]) ovr = 0;
            if (to_evt[c]) to = 1; else if (s_clr[c]) to = 0;
        end
        cur_ch = ch; cur_ovr = ovr; cur_to = to;
    endtask

    task automatic run_seg(input int len);
        for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            cyc = c;
            running = 1'b1;
            bus.frame_sync = s_sync[c];
            bus.dp_done    = s_done[c];
            bus.err_clr    = s_clr[c];
            bus.ch_en      = s_en[c];
            scan_in0       = 1'($urandom);
            scan_en        = 1'($urandom);
        end
        @(posedge clk); #1;
        running = 1'b0;
        bus.frame_sync = 0; bus.dp_done = 0; bus.err_clr = 0;
        scan_en = 0; scan_in0 = 0;
    endtask

    function automatic int count_starts(input int from, input int to_c);
        int n = 0;
        for (int c = from; c < to_c; c++) if (d_start[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_fd(input int from, input int to_c);
        int n = 0;
        for (int c = from; c < to_c; c++) if (d_fd[c] === 1'b1) n++;
        return n;
    endfunction

    // Compare process: every output, every cycle of a running segment.
    always @(negedge clk) begin
        if (running) begin
            check("dp_start",    cyc, 32'(bus.dp_start),    32'(e_start[cyc]));
            check("dp_ch",       cyc, 32'(bus.dp_ch),       32'(e_ch[cyc]));
            check("busy",        cyc, 32'(bus.busy),        32'(e_busy[cyc]));
            check("frame_done",  cyc, 32'(bus.frame_done),  32'(e_fd[cyc]));
            check("overrun",     cyc, 32'(bus.overrun),     32'(e_ovr[cyc]));
            check("timeout_err", cyc, 32'(bus.timeout_err), 32'(e_to[cyc]));
            check("scan_out0",   cyc, 32'(scan_out0),       32'd0);
            d_start[cyc] = bus.dp_start;
            d_fd[cyc]    = bus.frame_done;
            d_ovr[cyc]   = bus.overrun;
            d_to[cyc]    = bus.timeout_err;
        end
    end

    initial begin
        int fd, fd2, k, k2, iss2, len, r, dead;
        logic [NCH-1:0] mask;

        bus.frame_sync = 0; bus.ch_en = '0; bus.dp_done = 0; bus.err_clr = 0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_dp_start", 0, 32'(bus.dp_start), 0);
        check("rst_dp_ch",    0, 32'(bus.dp_ch), 0);
        check("rst_busy",     0, 32'(bus.busy), 0);
        check("rst_fdone",    0, 32'(bus.frame_done), 0);
        check("rst_overrun",  0, 32'(bus.overrun), 0);
        check("rst_timeout",  0, 32'(bus.timeout_err), 0);
        check("rst_scan",     0, 32'(scan_out0), 0);
        @(negedge clk) reset = 1'b1;

        // Reset asserted mid-WAIT on a channel that never answers.
        @(posedge clk); #1 bus.frame_sync = 1; bus.ch_en = 32'h1;
        @(posedge clk); #1 bus.frame_sync = 0; bus.ch_en = $urandom;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_busy", 0, 32'(bus.busy), 1);
        #2 reset = 1'b0;
        #1;
        check("arst_dp_start", 0, 32'(bus.dp_start), 0);
        check("arst_dp_ch",    0, 32'(bus.dp_ch), 0);
        check("arst_busy",     0, 32'(bus.busy), 0);
        check("arst_fdone",    0, 32'(bus.frame_done), 0);
        check("arst_overrun",  0, 32'(bus.overrun), 0);
        check("arst_timeout",  0, 32'(bus.timeout_err), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_dp_start", i, 32'(bus.dp_start), 0);
            check("post_rst_busy",     i, 32'(bus.busy), 0);
        end
        cur_ch = 0; cur_ovr = 0; cur_to = 0;

        // All channels, done 3 cycles after each start.
        plan_clear();
        plan_frame(2, '1, 0, -1, fd);
        len = fd + 4;
        build_exp(len);
        run_seg(len);
        check("full_model_len", 0, 32'(fd - 2), 32'd162);
        check("full_first_start", 4, 32'(d_start[4]), 1);
        check("full_fdone_at_162", 164, 32'(d_fd[164]), 1);
        check("full_start_count", 0, 32'(count_starts(0, len)), 32'd32);
        check("full_no_timeout", len - 1, 32'(d_to[len - 1]), 0);

        // Channels 0 and 31 only, then an all-zero mask back to back.
        plan_clear();
        plan_frame(1, 32'h8000_0001, 0, -1, fd);
        k2 = fd + 1;
        plan_frame(k2, '0, 0, -1, fd2);
        len = fd2 + 4;
        build_exp(len);
        run_seg(len);
        check("edge_start_ch0", 3, 32'(d_start[3]), 1);
        check("edge_start_ch31", 38, 32'(d_start[38]), 1);
        check("edge_start_count", 0, 32'(count_starts(0, k2)), 2);
        check("zero_model_len", 0, 32'(fd2 - k2), 32'd34);
        check("zero_fdone", k2 + 34, 32'(d_fd[k2 + 34]), 1);
        check("zero_no_start", k2, 32'(count_starts(k2, len)), 0);

        // Channel 5 never answers; clear, then clear coincident with a new timeout.
        plan_clear();
        plan_frame(1, 32'h0000_0060, 0, 5, fd);
        s_clr[90] = 1;
        k2 = fd + 1;
        plan_frame(k2, 32'h0000_0060, 0, 5, fd2);
        iss2 = k2 + 7;
        s_clr[iss2 + 64] = 1;
        len = fd2 + 3;
        build_exp(len);
        run_seg(len);
        check("to_model_evt", 72, 32'(to_evt[72]), 1);
        check("to_ch5_start", 8, 32'(d_start[8]), 1);
        check("to_not_early", 72, 32'(d_to[72]), 0);
        check("to_set", 73, 32'(d_to[73]), 1);
        check("to_ch6_start", 74, 32'(d_start[74]), 1);
        check("to_cleared", 91, 32'(d_to[91]), 0);
        check("to_before_2nd", iss2 + 64, 32'(d_to[iss2 + 64]), 0);
        check("to_set_beats_clr", iss2 + 65, 32'(d_to[iss2 + 65]), 1);

        // Done coincident with expiry, strobes during WAIT and FDONE, stray done in IDLE.
        plan_clear();
        plan_frame(2, 32'h0000_0003, 2, -1, fd);
        s_done[0] = 1;
        s_sync[20] = 1;
        s_clr[100] = 1;
        s_sync[fd] = 1;
        len = fd + 4;
        build_exp(len);
        run_seg(len);
        check("coin_model_len", 0, 32'(fd), 32'd166);
        check("coin_starts", 70, 32'(d_start[4] & d_start[70]), 1);
        check("coin_no_timeout", fd, 32'(d_to[fd]), 0);
        check("ovr_wait", 21, 32'(d_ovr[21]), 1);
        check("ovr_cleared", 101, 32'(d_ovr[101]), 0);
        check("ovr_fdone", fd + 1, 32'(d_ovr[fd + 1]), 1);
        check("ovr_one_frame", 0, 32'(count_fd(0, len)), 1);

        // Randomised frames with noise strobes, stray completions and clears.
        for (int seg = 0; seg < 6; seg++) begin
            plan_clear();
            k = $urandom_range(0, 3);
            for (int f = 0; f < 2; f++) begin
                r = $urandom_range(0, 7);
                mask = (r == 0) ? '0 : (r == 1) ? '1 : NCH'($urandom);
                dead = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NCH - 1) : -1;
                plan_frame(k, mask, 1, dead, fd);
                k = fd + 1 + $urandom_range(0, 3);
            end
            len = k + 2;
            add_noise(len);
            build_exp(len);
            run_seg(len);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
